sram_port_arbiter: RTL
======================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 19, word address width; DW, 32, data width; TMO, 255, memory-ack timeout in cycles (1..255).
REQ-002 Clock and reset SHALL be: clk_i  in  1  single clock, all logic rising-edge; rst_N_i  in  1  asynchronous active-low reset.
REQ-003 Master 0, the VGA read port, SHALL be: m0_req_i  in  1; m0_addr_i  in  AW; m0_ack_o  out  1.
REQ-004 Masters 1 (instruction) and 2 (data) SHALL each be: mX_req_i  in  1; mX_we_i  in  1; mX_addr_i  in  AW; mX_wdata_i  in  DW; mX_be_i  in  4 (byte enables); mX_ack_o  out  1; mX_err_o  out  1.
REQ-005 The shared read bus SHALL be: rdata_o  out  DW, valid only in the cycle where some mX_ack_o=1.
REQ-006 The memory port SHALL be: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  AW; mem_wdata_o  out  DW; mem_be_o  out  4; mem_ack_i  in  1; mem_rdata_i  in  DW.

Function
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-008 IDLE: when any mX_req_i=1, the block SHALL register the winner's index, we, addr, wdata and be, and go to ISSUE next cycle; otherwise it stays in IDLE.
REQ-009 Priority SHALL be: m0 strictly highest; between m1 and m2, round-robin via a 1-bit last-grant register. The one not granted last wins on a tie; after reset m1 wins the first tie.
REQ-010 ISSUE: mem_req_o=1 with the latched command for exactly one cycle, then WAIT.
REQ-011 WAIT: the block SHALL count cycles from 1. On mem_ack_i=1 it asserts the winner's mX_ack_o for one cycle, sets rdata_o=mem_rdata_i in that same cycle (combinational pass-through), and returns to IDLE.
REQ-012 If mem_ack_i=1 arrives in the ISSUE cycle, it SHALL be treated as arriving in WAIT, giving a minimum of 2 cycles from grant to ack.
REQ-013 Timeout: if the count reaches TMO without mem_ack_i, the block SHALL assert mX_ack_o and mX_err_o together for one cycle (rdata_o=0) and return to IDLE. For m0 only ack is raised, since m0 has no err output.
REQ-014 mem_ack_i in IDLE SHALL be ignored.
REQ-015 Master 0 is read-only: mem_we_o=0 and mem_be_o=4'hF when m0 is granted.
REQ-016 Masters SHALL hold req and command stable until their ack. Request inputs are sampled only in IDLE; changes in ISSUE or WAIT have no effect on the current transaction.
REQ-017 Back-to-back throughput SHALL be at most one transaction per 3 cycles (IDLE, ISSUE, WAIT) with immediate ack.
REQ-018 The last-grant register SHALL update only on an m1 or m2 grant, never on an m0 grant.
REQ-019 Only one mX_ack_o SHALL be high in any cycle.
REQ-020 The timeout counter SHALL be 8 bits, SHALL clear on entry to ISSUE, and SHALL never wrap.

Reset
REQ-021 While rst_N_i=0, the FSM SHALL be in IDLE, the last-grant register SHALL point to m2 (so m1 wins the first tie), and the counter SHALL be 0.
REQ-022 While rst_N_i=0, all outputs SHALL be 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, every mX_ack_o, every mX_err_o, and rdata_o.
REQ-023 Reset asserted mid-transaction SHALL abort it with no ack to any master. A mem_ack_i arriving after reset release SHALL be ignored per REQ-014.

Verification
REQ-024 m1 read at addr 0x00100 with mem_ack_i returned 2 cycles after mem_req_o, mem_rdata_i=0xDEADBEEF -> mem_req_o is a one-cycle pulse, m1_ack_o=1 with rdata_o=0xDEADBEEF, m1_err_o=0.
REQ-025 m1 and m2 both requesting continuously, memory acking immediately -> grants alternate m1, m2, m1, m2, one every 3 cycles.
REQ-026 m0, m1 and m2 all requesting -> m0 granted first; after m0's ack, the m1/m2 order follows round-robin and is unaffected by the m0 grant.
REQ-027 m2 write with wdata 0x12345678, be 4'b0011 -> mem_we_o=1, mem_wdata_o=0x12345678, mem_be_o=4'b0011 in the ISSUE cycle.
REQ-028 With TMO=4, m2 request and mem_ack_i held 0 -> m2_ack_o=1 and m2_err_o=1 on the 4th WAIT cycle, then IDLE; a late mem_ack_i is ignored.
REQ-029 rst_N_i pulsed low during WAIT for an m1 request -> all outputs 0 immediately (asynchronously), no m1_ack_o; after release, the next tie between m1 and m2 grants m1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Three-master arbiter in front of a single-ported SRAM: m0 (VGA read) has fixed top priority,
// m1/m2 share round-robin. One command is outstanding at a time, with a timeout on the memory ack.
module sram_port_arbiter #(
  parameter int AW  = 19,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          clk_i,
  input  logic          rst_N_i,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  output logic          m0_ack_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic [3:0]    m1_be_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  input  logic          m2_req_i,
  input  logic          m2_we_i,
  input  logic [AW-1:0] m2_addr_i,
  input  logic [DW-1:0] m2_wdata_i,
  input  logic [3:0]    m2_be_i,
  output logic          m2_ack_o,
  output logic          m2_err_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  // state | meaning
  // IDLE  | sample requests, latch the winner's command
  // ISSUE | mem_req_o high for one cycle; an early ack is held until WAIT
  // WAIT  | count cycles from 1 until memory ack or TMO

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t        r_state;
  logic [1:0]    r_gnt;
  logic          r_last_m2;
  logic [7:0]    r_cnt;
  logic          r_ack_pend;
  logic [DW-1:0] r_pend_rdata;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [3:0]    r_mem_be;

  logic          w_any_req;
  logic [1:0]    w_win;
  logic          w_in_wait;
  logic          w_ack_hit;
  logic          w_tmo;
  logic          w_done;

  always_comb begin
    w_any_req = m0_req_i | m1_req_i | m2_req_i;
    if (m0_req_i)
      w_win = 2'd0;
    else if (m1_req_i && (!m2_req_i || r_last_m2))
      w_win = 2'd1;
    else
      w_win = 2'd2;
  end

  // An ack taken during ISSUE is replayed in the first WAIT cycle, so r_ack_pend counts as a hit.
  assign w_in_wait = (r_state == S_WAIT);
  assign w_ack_hit = w_in_wait && (r_ack_pend || mem_ack_i);
  assign w_tmo     = w_in_wait && !w_ack_hit && (r_cnt == TMO_C);
  assign w_done    = w_ack_hit || w_tmo;

  always_ff @(posedge clk_i or negedge rst_N_i) begin
    if (!rst_N_i) begin
      r_state      <= S_IDLE;
      r_gnt        <= 2'd0;
      r_last_m2    <= 1'b1;
      r_cnt        <= 8'd0;
      r_ack_pend   <= 1'b0;
      r_pend_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= 4'h0;
    end else begin
      r_mem_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_ISSUE;
            r_gnt      <= w_win;
            r_mem_req  <= 1'b1;
            r_cnt      <= 8'd0;
            r_ack_pend <= 1'b0;
            case (w_win)
              2'd0: begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= m0_addr_i;
                r_mem_wdata <= '0;
                r_mem_be    <= 4'hF;
              end
              2'd1: begin
                r_mem_we    <= m1_we_i;
                r_mem_addr  <= m1_addr_i;
                r_mem_wdata <= m1_wdata_i;
                r_mem_be    <= m1_be_i;
                r_last_m2   <= 1'b0;
              end
              default: begin
                r_mem_we    <= m2_we_i;
                r_mem_addr  <= m2_addr_i;
                r_mem_wdata <= m2_wdata_i;
                r_mem_be    <= m2_be_i;
                r_last_m2   <= 1'b1;
              end
            endcase
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= 8'd1;
          if (mem_ack_i) begin
            r_ack_pend   <= 1'b1;
            r_pend_rdata <= mem_rdata_i;
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_state    <= S_IDLE;
            r_ack_pend <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_ack_o = w_done && (r_gnt == 2'd0);
  assign m1_ack_o = w_done && (r_gnt == 2'd1);
  assign m2_ack_o = w_done && (r_gnt == 2'd2);
  assign m1_err_o = w_tmo && (r_gnt == 2'd1);
  assign m2_err_o = w_tmo && (r_gnt == 2'd2);
  assign rdata_o  = !w_ack_hit ? '0 : (r_ack_pend ? r_pend_rdata : mem_rdata_i);

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;

endmodule
